// File: rtl/aclint_mmio.sv
`default_nettype none
// ============================================================================
// Module   : aclint_mmio
// Brief    : Single-hart ACLINT responder (MSIP, MTIMECMP, MTIME, SETSSIP)
//            on the 64-bit memory bus. One-cycle response, no backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module aclint_mmio #(
   parameter logic [63:0] BASE       = 64'h0200_0000,
   parameter int          DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst,          // asynchronous, active-low
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [63:0]             req_addr,
   input  logic                    req_wen,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wmask,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    msip,
   output logic                    mtip,
   output logic                    setssip
);

   localparam int              c_NB       = DATA_WIDTH / 8;
   localparam logic [12:0]     c_IDX_MSIP = 13'h0000;   // offset 0x0000
   localparam logic [12:0]     c_IDX_CMP  = 13'h0800;   // offset 0x4000
   localparam logic [12:0]     c_IDX_TIME = 13'h0FFF;   // offset 0x7FF8
   localparam logic [12:0]     c_IDX_SSIP = 13'h1000;   // offset 0x8000
   localparam logic [63:0]     c_WIN_SIZE = 64'h0000_0000_0000_C000;
   localparam logic [DATA_WIDTH-1:0] c_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   // Registered state
   logic                  ready_q;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  msip_q,      msip_d;
   logic                  setssip_q,   setssip_d;
   logic [DATA_WIDTH-1:0] mtimecmp_q,  mtimecmp_d;
   logic [DATA_WIDTH-1:0] mtime_q,     mtime_d;

   // Address decode
   logic [63:0]           w_off;
   logic [12:0]           w_idx;
   logic [2:0]            w_unused_off;
   logic                  w_in_win;
   logic                  w_accept;
   logic                  w_wr;
   logic                  w_sel_msip, w_sel_cmp, w_sel_time, w_sel_ssip;
   logic [DATA_WIDTH-1:0] w_rd_data;

   // Keep the lanes of old that wmask does not enable.
   function automatic logic [DATA_WIDTH-1:0] f_merge(
      input logic [DATA_WIDTH-1:0] old_v,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [c_NB-1:0]       wmask
   );
      logic [DATA_WIDTH-1:0] r;
      r = old_v;
      for (int b = 0; b < c_NB; b++) begin
         if (wmask[b]) begin
            r[b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
      return r;
   endfunction

   assign w_off        = req_addr - BASE;
   assign w_idx        = w_off[15:3];
   assign w_unused_off = w_off[2:0];          // bus guarantees 8-byte alignment
   assign w_in_win     = (w_off < c_WIN_SIZE); // wraps large for addr < BASE
   assign w_accept     = req_valid && ready_q;
   assign w_wr         = w_accept && req_wen;

   assign w_sel_msip   = w_in_win && (w_idx == c_IDX_MSIP);
   assign w_sel_cmp    = w_in_win && (w_idx == c_IDX_CMP);
   assign w_sel_time   = w_in_win && (w_idx == c_IDX_TIME);
   assign w_sel_ssip   = w_in_win && (w_idx == c_IDX_SSIP);

   // Read mux; SETSSIP and unmapped offsets read as zero.
   always_comb begin
      w_rd_data = '0;
      if (w_sel_msip) begin
         w_rd_data = {{(DATA_WIDTH-1){1'b0}}, msip_q};
      end else if (w_sel_cmp) begin
         w_rd_data = mtimecmp_q;
      end else if (w_sel_time) begin
         w_rd_data = mtime_q;
      end
   end

   // Next-state for all registers; a write to MTIME replaces that cycle's tick.
   always_comb begin
      rsp_valid_d = w_accept;
      rsp_rdata_d = (w_accept && !req_wen) ? w_rd_data : '0;
      msip_d      = msip_q;
      mtimecmp_d  = mtimecmp_q;
      mtime_d     = mtime_q + c_ONE;
      setssip_d   = w_wr && w_sel_ssip && req_wmask[0] && req_wdata[0];
      if (w_wr && w_sel_msip && req_wmask[0]) begin
         msip_d = req_wdata[0];
      end
      if (w_wr && w_sel_cmp) begin
         mtimecmp_d = f_merge(mtimecmp_q, req_wdata, req_wmask);
      end
      if (w_wr && w_sel_time) begin
         mtime_d = f_merge(mtime_q, req_wdata, req_wmask);
      end
   end

   // State registers with asynchronous reset to architectural reset values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         msip_q      <= 1'b0;
         setssip_q   <= 1'b0;
         mtimecmp_q  <= '1;
         mtime_q     <= '0;
      end else begin
         ready_q     <= 1'b1;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         msip_q      <= msip_d;
         setssip_q   <= setssip_d;
         mtimecmp_q  <= mtimecmp_d;
         mtime_q     <= mtime_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign msip      = msip_q;
   assign setssip   = setssip_q;
   assign mtip      = (mtime_q >= mtimecmp_q);

endmodule
`default_nettype wire

// File: tb/tb_aclint_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_aclint_mmio
// Brief    : Self-checking bench for aclint_mmio with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aclint_mmio;

   localparam logic [63:0] c_BASE = 64'h0200_0000;
   localparam logic [63:0] c_MSIP = c_BASE + 64'h0000;
   localparam logic [63:0] c_CMP  = c_BASE + 64'h4000;
   localparam logic [63:0] c_TIME = c_BASE + 64'h7FF8;
   localparam logic [63:0] c_SSIP = c_BASE + 64'h8000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        req_wen;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        msip;
   logic        mtip;
   logic        setssip;

   int checks = 0;
   int errors = 0;

   aclint_mmio #(.BASE(c_BASE), .DATA_WIDTH(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wen   (req_wen),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .msip      (msip),
      .mtip      (mtip),
      .setssip   (setssip)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic        m_ready, m_rv, m_msip, m_ss;
   logic [63:0] m_rd, m_cmp, m_mtime;
   logic        m_acc;

   assign m_acc = req_valid && m_ready;

   function automatic logic [63:0] lanes(input logic [63:0] o, input logic [63:0] w,
                                         input logic [7:0] m);
      logic [63:0] r;
      for (int b = 0; b < 8; b++) begin
         r[b*8 +: 8] = m[b] ? w[b*8 +: 8] : o[b*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [63:0] model_read(input logic [63:0] a);
      if (a == c_MSIP) return {63'd0, m_msip};
      if (a == c_CMP)  return m_cmp;
      if (a == c_TIME) return m_mtime;
      return 64'd0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ready <= 1'b0; m_rv <= 1'b0; m_rd <= 64'd0; m_msip <= 1'b0;
         m_ss <= 1'b0; m_cmp <= '1; m_mtime <= 64'd0;
      end else begin
         m_ready <= 1'b1;
         m_rv    <= m_acc;
         m_rd    <= (m_acc && !req_wen) ? model_read(req_addr) : 64'd0;
         m_ss    <= m_acc && req_wen && req_addr == c_SSIP && req_wmask[0] && req_wdata[0];
         if (m_acc && req_wen && req_addr == c_MSIP && req_wmask[0]) m_msip <= req_wdata[0];
         if (m_acc && req_wen && req_addr == c_CMP) m_cmp <= lanes(m_cmp, req_wdata, req_wmask);
         if (m_acc && req_wen && req_addr == c_TIME) m_mtime <= lanes(m_mtime, req_wdata, req_wmask);
         else m_mtime <= m_mtime + 64'd1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst) begin
         check("req_ready", {63'd0, req_ready}, {63'd0, m_ready});
         check("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_rv});
         if (m_rv) check("rsp_rdata", rsp_rdata, m_rd);
         check("msip", {63'd0, msip}, {63'd0, m_msip});
         check("mtip", {63'd0, mtip}, {63'd0, (m_mtime >= m_cmp)});
         check("setssip", {63'd0, setssip}, {63'd0, m_ss});
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [7:0] m);
      req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
      @(negedge clk);
      req_valid = 1'b0; req_wen = 1'b0; req_wmask = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst = 1'b0; req_valid = 1'b0; req_addr = 64'd0; req_wen = 1'b0;
      req_wdata = 64'd0; req_wmask = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ready", {63'd0, req_ready}, 64'd0);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_outs", {61'd0, msip, mtip, setssip}, 64'd0);
      rst = 1'b1;
      #1 check("ready_before_edge", {63'd0, req_ready}, 64'd0);

      // MTIME read in the 10th cycle after release, then MTIMECMP reset value
      repeat (9) @(negedge clk);
      do_req(c_TIME, 1'b0, 64'd0, 8'h00);
      check("mtime_first_read", rsp_rdata, 64'd9);
      do_req(c_CMP, 1'b0, 64'd0, 8'h00);
      check("mtimecmp_reset", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      check("mtip_low", {63'd0, mtip}, 64'd0);

      // Timer compare at now+20
      do_req(c_CMP, 1'b1, m_mtime + 64'd20, 8'hFF);
      cnt = 0;
      while (!mtip && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check("mtip_low_cycles", 64'(cnt), 64'd19);
      repeat (3) @(negedge clk);
      check("mtip_stays_high", {63'd0, mtip}, 64'd1);
      do_req(c_CMP, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      check("mtip_cleared", {63'd0, mtip}, 64'd0);

      // MSIP
      do_req(c_MSIP, 1'b1, 64'hFFFF_FFFF, 8'h0F);
      check("msip_set", {63'd0, msip}, 64'd1);
      do_req(c_MSIP, 1'b0, 64'd0, 8'h00);
      check("msip_read", rsp_rdata, 64'd1);
      do_req(c_MSIP, 1'b1, 64'd0, 8'hF0);
      check("msip_mask_f0", {63'd0, msip}, 64'd1);
      do_req(c_MSIP, 1'b1, 64'd0, 8'hFF);
      check("msip_clear", {63'd0, msip}, 64'd0);

      // Wrap
      do_req(c_TIME, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
      do_req(c_CMP, 1'b1, 64'd5, 8'hFF);
      check("wrap_mtip_high", {63'd0, mtip}, 64'd1);
      @(negedge clk);
      check("wrap_mtip_low", {63'd0, mtip}, 64'd0);
      repeat (4) @(negedge clk);
      check("wrap_mtip_at4", {63'd0, mtip}, 64'd0);
      @(negedge clk);
      check("wrap_mtip_at5", {63'd0, mtip}, 64'd1);

      // Partial MTIME write, back-to-back
      do_req(c_TIME, 1'b1, 64'h0000_0000_0000_0100, 8'hFF);
      do_req(c_TIME, 1'b1, 64'h1234_5678_DEAD_BEEF, 8'hF0);
      do_req(c_TIME, 1'b0, 64'd0, 8'h00);
      check("mtime_partial", rsp_rdata, 64'h1234_5678_0000_0100);
      do_req(c_CMP, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);

      // SETSSIP doorbell and zero reads
      do_req(c_SSIP, 1'b1, 64'd1, 8'h01);
      check("setssip_pulse", {63'd0, setssip}, 64'd1);
      @(negedge clk);
      check("setssip_one_cycle", {63'd0, setssip}, 64'd0);
      do_req(c_SSIP, 1'b1, 64'd0, 8'hFF);
      check("setssip_no_pulse", {63'd0, setssip}, 64'd0);
      do_req(c_SSIP, 1'b0, 64'd0, 8'h00);
      check("ssip_read_valid", {63'd0, rsp_valid}, 64'd1);
      check("ssip_read_zero", rsp_rdata, 64'd0);
      do_req(c_BASE + 64'h1000, 1'b0, 64'd0, 8'h00);
      check("unmapped_valid", {63'd0, rsp_valid}, 64'd1);
      check("unmapped_zero", rsp_rdata, 64'd0);
      do_req(c_BASE + 64'hC000, 1'b1, 64'd0, 8'hFF);    // outside window, ignored
      do_req(c_BASE - 64'h8, 1'b0, 64'd0, 8'h00);
      check("below_base_zero", rsp_rdata, 64'd0);

      // Reset mid-stream with msip, mtip, setssip and a response all active
      do_req(c_MSIP, 1'b1, 64'd1, 8'h01);
      do_req(c_CMP, 1'b1, 64'd0, 8'hFF);
      req_valid = 1'b1; req_addr = c_SSIP; req_wen = 1'b1; req_wdata = 64'd1; req_wmask = 8'h01;
      @(posedge clk);
      #1 check("pre_rst_active", {60'd0, rsp_valid, msip, mtip, setssip}, 64'hF);
      req_valid = 1'b0; req_wen = 1'b0;
      #1 rst = 1'b0;
      #1 check("async_rst_outs", {59'd0, req_ready, rsp_valid, msip, mtip, setssip}, 64'd0);
      check("async_rst_rdata", rsp_rdata, 64'd0);
      @(negedge clk);
      check("rst_held_ssip", {63'd0, setssip}, 64'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      do_req(c_TIME, 1'b0, 64'd0, 8'h00);
      check("mtime_after_rst", rsp_rdata, 64'd3);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
